// File: rtl/counter_interval_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_interval_ctrl_pkg
// Shared types and constants for the interval-timer sequencer that drives a
// 4-bit loadable up-counter.
//   state_t  : sequencer states (IDLE, LOAD, RUN)
//   CNT_W    : width of the external counter's data path
//   CNT_MAX  : counter value at which the counter raises carry
// -----------------------------------------------------------------------------
package counter_interval_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned    CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/counter_interval_ctrl_prescale_strobe.sv
// -----------------------------------------------------------------------------
// prescale_strobe
// Prescale divider for the interval timer. While enabled and not held it
// produces one strobe every (i_div + 1) cycles. The internal counter is
// forced to zero whenever the block is not enabled, so every RUN phase
// starts with a fresh prescale period.
// Ports:
//   i_clock   : clock, rising edge
//   i_clear_n : synchronous active-low reset
//   i_run_en  : prescaler enabled (sequencer in RUN)
//   i_hold    : freeze the prescaler and suppress the strobe
//   i_div     : captured divider value
//   o_strobe  : combinational count strobe for this cycle
// -----------------------------------------------------------------------------
module prescale_strobe #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic             i_run_en,
    input  logic             i_hold,
    input  logic [PRE_W-1:0] i_div,
    output logic             o_strobe
);

    logic [PRE_W-1:0] r_pre;
    logic             w_wrap;

    assign w_wrap   = (r_pre == i_div);
    assign o_strobe = i_run_en & ~i_hold & w_wrap;

    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_pre <= '0;
        end else if (!i_run_en) begin
            r_pre <= '0;
        end else if (!i_hold) begin
            if (w_wrap) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_interval_ctrl.sv
// -----------------------------------------------------------------------------
// counter_interval_ctrl
// Sequencer that uses an external 4-bit loadable up-counter as a programmable
// interval timer: load preset, issue prescaled count strobes, detect terminal
// count via the counter's carry, then reload (periodic) or stop (one-shot).
// Ports:
//   clock, clear        : clock and synchronous active-low reset
//   start, stop, hold   : command interface (stop has highest priority)
//   mode, preset, div   : configuration, captured at start
//   cnt_count, cnt_load : strobes to the counter (never both high)
//   cnt_inp             : load value for the counter (captured preset)
//   cnt_carry           : counter carry (count active and value 15)
//   busy                : sequencer not idle
//   tick, done          : registered 1-cycle pulses (terminal count / one-shot end)
//   ticks               : saturating count of terminal events since last start
// -----------------------------------------------------------------------------
module counter_interval_ctrl
    import counter_interval_ctrl_pkg::*;
#(
    parameter int unsigned PRE_W   = 4,
    parameter int unsigned TICKS_W = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic [CNT_W-1:0]   preset,
    input  logic [PRE_W-1:0]   div,
    output logic               cnt_count,
    output logic               cnt_load,
    output logic [CNT_W-1:0]   cnt_inp,
    input  logic               cnt_carry,
    output logic               busy,
    output logic               tick,
    output logic               done,
    output logic [TICKS_W-1:0] ticks
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_preset_q;
    logic [PRE_W-1:0]   r_div_q;
    logic               r_mode_q;
    logic               r_tick;
    logic               r_done;
    logic [TICKS_W-1:0] r_ticks;

    logic               w_strobe;
    logic               w_terminal;
    logic               w_capture;

    prescale_strobe #(
        .PRE_W (PRE_W)
    ) u_prescale (
        .i_clock   (clock),
        .i_clear_n (clear),
        .i_run_en  (r_state == RUN),
        .i_hold    (hold),
        .i_div     (r_div_q),
        .o_strobe  (w_strobe)
    );

    // stop masks the strobe, which in turn masks the terminal event, so an
    // abort coinciding with carry produces neither tick nor done.
    assign cnt_count  = w_strobe & ~stop;
    assign cnt_load   = (r_state == LOAD);
    assign cnt_inp    = r_preset_q;
    assign busy       = (r_state != IDLE);
    assign tick       = r_tick;
    assign done       = r_done;
    assign ticks      = r_ticks;

    assign w_terminal = cnt_count & cnt_carry;
    assign w_capture  = (r_state == IDLE) & start & ~stop;

    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start) w_state_next = LOAD;
                LOAD: w_state_next = RUN;
                RUN:  if (w_terminal) w_state_next = r_mode_q ? LOAD : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state    <= IDLE;
            r_preset_q <= '0;
            r_div_q    <= '0;
            r_mode_q   <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_ticks    <= '0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_terminal;
            r_done  <= w_terminal & ~r_mode_q;
            if (w_capture) begin
                r_preset_q <= preset;
                r_div_q    <= div;
                r_mode_q   <= mode;
                r_ticks    <= '0;
            end else if (w_terminal && !(&r_ticks)) begin
                r_ticks <= r_ticks + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_interval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_interval_ctrl
// Two sequencer instances (TICKS_W=8 and TICKS_W=2) share the stimulus, each
// driving its own copy of the 4-bit loadable counter. A behavioural model that
// tracks "strobes remaining" and prescale phase is compared every cycle;
// directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_counter_interval_ctrl;

    logic       clock  = 1'b0;
    logic       clear  = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       hold   = 1'b0;
    logic       mode   = 1'b0;
    logic [3:0] preset = 4'd0;
    logic [3:0] div    = 4'd0;

    logic [1:0] d_count, d_load, d_carry, d_busy, d_tick, d_done;
    logic [3:0] d_inp [2];
    logic [7:0] d_ticks0;
    logic [1:0] d_ticks1;
    logic [3:0] cval [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    typedef struct {
        string nm;
        int    act;
        int    exp;
    } lit_t;
    lit_t lit_q[$];

    always #5 clock = ~clock;

    counter_interval_ctrl #(.PRE_W(4), .TICKS_W(8)) u_dut0 (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .hold(hold),
        .mode(mode), .preset(preset), .div(div),
        .cnt_count(d_count[0]), .cnt_load(d_load[0]), .cnt_inp(d_inp[0]),
        .cnt_carry(d_carry[0]), .busy(d_busy[0]), .tick(d_tick[0]),
        .done(d_done[0]), .ticks(d_ticks0)
    );

    counter_interval_ctrl #(.PRE_W(4), .TICKS_W(2)) u_dut1 (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .hold(hold),
        .mode(mode), .preset(preset), .div(div),
        .cnt_count(d_count[1]), .cnt_load(d_load[1]), .cnt_inp(d_inp[1]),
        .cnt_carry(d_carry[1]), .busy(d_busy[1]), .tick(d_tick[1]),
        .done(d_done[1]), .ticks(d_ticks1)
    );

    // The team's 4-bit loadable up-counter, one per instance, sharing clear.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!clear)          cval[k] <= 4'd0;
            else if (d_load[k])  cval[k] <= d_inp[k];
            else if (d_count[k]) cval[k] <= cval[k] + 4'd1;
        end
    end
    assign d_carry[0] = d_count[0] && (cval[0] == 4'd15);
    assign d_carry[1] = d_count[1] && (cval[1] == 4'd15);

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Behavioural model state (values visible in the current cycle).
    bit m_busy = 0, m_loading = 0, m_mode = 0, m_tick = 0, m_done = 0;
    int m_preset = 0, m_div = 0, m_phase = 0, m_remain = 0, m_nticks = 0;

    task automatic mcheck(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Single compare process: per-cycle model checks, queued literal checks,
    // then advance the model with the inputs applied during this cycle.
    always @(negedge clock) begin
        bit   e_count, e_term;
        int   e_t0, e_t1;
        lit_t it;
        e_count = m_busy && !m_loading && !hold && !stop && (m_phase == m_div);
        e_term  = e_count && (m_remain == 1);
        e_t0    = (m_nticks > 255) ? 255 : m_nticks;
        e_t1    = (m_nticks > 3) ? 3 : m_nticks;
        for (int k = 0; k < 2; k++) begin
            mcheck($sformatf("dut%0d.busy", k),  int'(d_busy[k]),  int'(m_busy));
            mcheck($sformatf("dut%0d.load", k),  int'(d_load[k]),  int'(m_busy && m_loading));
            mcheck($sformatf("dut%0d.count", k), int'(d_count[k]), int'(e_count));
            mcheck($sformatf("dut%0d.inp", k),   int'(d_inp[k]),   m_preset);
            mcheck($sformatf("dut%0d.carry", k), int'(d_carry[k]), int'(e_term));
            mcheck($sformatf("dut%0d.tick", k),  int'(d_tick[k]),  int'(m_tick));
            mcheck($sformatf("dut%0d.done", k),  int'(d_done[k]),  int'(m_done));
        end
        mcheck("dut0.ticks", int'(d_ticks0), e_t0);
        mcheck("dut1.ticks", int'(d_ticks1), e_t1);
        while (lit_q.size() > 0) begin
            it = lit_q.pop_front();
            mcheck(it.nm, it.act, it.exp);
        end

        if (!clear) begin
            m_busy = 0; m_loading = 0; m_preset = 0; m_div = 0; m_mode = 0;
            m_tick = 0; m_done = 0; m_nticks = 0;
        end else begin
            m_tick = 0;
            m_done = 0;
            if (stop) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_loading = 1; m_nticks = 0;
                    m_preset = int'(preset); m_div = int'(div); m_mode = mode;
                end
            end else if (m_loading) begin
                m_loading = 0;
                m_phase   = 0;
                m_remain  = 16 - m_preset;
            end else if (!hold) begin
                if (m_phase == m_div) begin
                    m_phase = 0;
                    m_remain--;
                    if (m_remain == 0) begin
                        m_nticks++;
                        m_tick = 1;
                        if (m_mode) m_loading = 1;
                        else begin
                            m_busy = 0;
                            m_done = 1;
                        end
                    end
                end else begin
                    m_phase++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        lit_q.push_back('{nm, act, exp});
    endtask

    task automatic start_run(input int p, input int d, input bit m);
        preset = p[3:0];
        div    = d[3:0];
        mode   = m;
        start  = 1'b1;
        cyc(1);
        start  = 1'b0;
        preset = 4'd0;
        div    = 4'd0;
        lit("start_load", int'(d_load[0]), 1);
    endtask

    task automatic wait_tick(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (d_tick[0]) begin
                t = cyc_n;
                break;
            end
        end
        if (t < 0) lit("tick_timeout", 0, 1);
    endtask

    task automatic stop_run();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        lit("stopped_busy", int'(d_busy[0]), 0);
    endtask

    initial begin
        int n_str, carry_at, t0, t1, t2;

        // Reset held with start asserted.
        clear = 1'b0;
        start = 1'b1;
        cyc(2);
        lit("rst_busy",  int'(d_busy[0]),  0);
        lit("rst_load",  int'(d_load[0]),  0);
        lit("rst_count", int'(d_count[0]), 0);
        lit("rst_ticks", int'(d_ticks0),   0);
        lit("rst_tick",  int'(d_tick[0]),  0);
        lit("rst_done",  int'(d_done[0]),  0);
        clear = 1'b1;
        start = 1'b0;
        cyc(1);

        // One-shot: preset 12, div 0 -> four strobes, carry on the fourth.
        start_run(12, 0, 1'b0);
        n_str = 0;
        carry_at = 0;
        for (int i = 0; i < 40 && d_busy[0]; i++) begin
            if (d_count[0]) begin
                n_str++;
                if (d_carry[0]) carry_at = n_str;
            end
            cyc(1);
        end
        lit("os_strobes",  n_str, 4);
        lit("os_carry_at", carry_at, 4);
        lit("os_tick",     int'(d_tick[0]), 1);
        lit("os_done",     int'(d_done[0]), 1);
        lit("os_ticks",    int'(d_ticks0),  1);
        cyc(1);
        lit("os_tick_low", int'(d_tick[0]), 0);
        lit("os_done_low", int'(d_done[0]), 0);

        // Periodic prescaled: preset 14, div 2 -> ticks 7 cycles apart.
        start_run(14, 2, 1'b1);
        wait_tick(60, t0);
        wait_tick(60, t1);
        wait_tick(60, t2);
        lit("per_gap1",  t1 - t0, 7);
        lit("per_gap2",  t2 - t1, 7);
        lit("per_ticks", int'(d_ticks0), 3);
        stop_run();

        // Hold: preset 13, div 1 -> 7-cycle period stretched by 5.
        start_run(13, 1, 1'b1);
        wait_tick(60, t0);
        cyc(2);
        hold = 1'b1;
        cyc(5);
        hold = 1'b0;
        wait_tick(60, t1);
        wait_tick(60, t2);
        lit("hold_gap",  t1 - t0, 12);
        lit("after_gap", t2 - t1, 7);
        stop_run();

        // Stop coinciding with the terminal event.
        start_run(15, 0, 1'b1);
        wait_tick(60, t0);
        wait_tick(60, t1);
        cyc(1);
        lit("pre_stop_count", int'(d_count[0]), 1);
        lit("pre_stop_carry", int'(d_carry[0]), 1);
        stop = 1'b1;
        #1;
        lit("stop_count", int'(d_count[0]), 0);
        cyc(1);
        stop = 1'b0;
        lit("stop_busy",  int'(d_busy[0]), 0);
        lit("stop_tick",  int'(d_tick[0]), 0);
        lit("stop_done",  int'(d_done[0]), 0);
        lit("stop_ticks", int'(d_ticks0),  2);

        // Start while busy is ignored; 2-bit tick counter saturates.
        start_run(15, 0, 1'b1);
        wait_tick(60, t0);
        wait_tick(60, t1);
        cyc(1);
        start = 1'b1;
        preset = 4'd3;
        cyc(1);
        start = 1'b0;
        preset = 4'd0;
        lit("busy_start_ticks", int'(d_ticks0), 3);
        for (int i = 0; i < 3; i++) wait_tick(60, t2);
        lit("sat_ticks8", int'(d_ticks0), 6);
        lit("sat_ticks2", int'(d_ticks1), 3);
        lit("sat_inp",    int'(d_inp[0]), 15);
        stop_run();

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_interval_ctrl.md
Name: counter_interval_ctrl

Overview:
Sequencer that drives the team's 4-bit loadable gate-level up-counter (count/load/inp/carry) as a programmable interval timer. It loads a preset, issues prescaled count strobes, watches the counter's carry for terminal count, and either reloads (periodic) or stops (one-shot). It sits between a simple start/stop command interface and one counter instance. The counter's clock and clear are wired to the same clock and clear nets as this block.

Parameters:
PRE_W, 4, width of the prescale divider field and the internal prescale counter.
TICKS_W, 8, width of the saturating tick counter output.

Ports:
clock  input  1  system clock; all state updates on the rising edge
clear  input  1  synchronous active-low reset
start  input  1  start request; sampled only in IDLE
stop  input  1  abort request; highest priority
hold  input  1  pause; freezes the prescaler and suppresses count strobes
mode  input  1  0 = one-shot, 1 = periodic; captured at start
preset  input  4  counter load value, bit 0 = LSB; captured at start
div  input  PRE_W  prescale value; one count strobe every div+1 RUN cycles; captured at start
cnt_count  output  1  to counter count input
cnt_load  output  1  to counter load input
cnt_inp  output  4  to counter inp, bit 0 = LSB; equals captured preset
cnt_carry  input  1  from counter carry; high when count is active and the counter value is 15
busy  output  1  high when state != IDLE
tick  output  1  registered 1-cycle pulse per terminal count
done  output  1  registered 1-cycle pulse at one-shot completion
ticks  output  TICKS_W  terminal counts since last start; saturates at all-ones

Behaviour:
- States: IDLE, LOAD, RUN. Encoded in a registered state; the next-state logic is combinational.
- Reset (clear=0 at an edge): state=IDLE, pre=0, preset_q=0, div_q=0, mode_q=0, tick=0, done=0, ticks=0. As a result cnt_load=0, cnt_count=0, cnt_inp=0, busy=0.
- IDLE: if start=1 and stop=0, capture preset, div and mode, clear ticks, and go to LOAD. Otherwise stay in IDLE.
- LOAD: cnt_load=1 and cnt_count=0 for exactly one cycle; cnt_inp=preset_q. Next state is RUN with pre=0. hold has no effect in LOAD.
- RUN, prescaler:
  - If hold=0 and pre==div_q: cnt_count=1 (combinational) and pre<=0.
  - Else if hold=0: pre<=pre+1.
  - If hold=1: pre holds and cnt_count=0.
- Terminal event is a cycle with cnt_count=1 and cnt_carry=1. On that event:
  - tick<=1 in the next cycle; ticks<=ticks+1, saturating.
  - Periodic mode: go to LOAD.
  - One-shot mode: go to IDLE and set done<=1 in the next cycle.
- Period (periodic mode): (16-preset)*(div+1)+1 cycles between tick pulses. preset=15 gives 1 strobe per interval.
- cnt_load and cnt_count are never both 1.
- stop=1 in any state: next state is IDLE, cnt_count=0 this cycle, and no tick/done is produced, even if the terminal event coincides. stop and start together in IDLE: remain in IDLE.
- start while busy is ignored. preset/div/mode changes while busy are ignored until the next start.
- A reset mid-RUN returns to IDLE in the same edge. The counter is cleared by the shared clear.
- tick and done are high for 1 cycle only and are low in all other cycles.

Decomposition:
- Shared package:
  - state enum {IDLE, LOAD, RUN}.
  - Constant CNT_MAX=4'd15.
  - Constant CNT_W=4.
- Sub-module: prescale_strobe. Holds the pre counter and takes div_q, hold and run_en; outputs strobe.
- The FSM, tick/done registers and ticks counter stay in the top module.
- Testbench instantiates the existing 4-bit counter together with this block.

Test Plan:
- Reset: hold clear=0 for 2 cycles with start=1 -> busy=0, cnt_load=0, cnt_count=0, ticks=0, tick=0, done=0.
- One-shot: preset=12, div=0, mode=0, start pulse -> cnt_load high for 1 cycle, then 4 consecutive cnt_count pulses. carry is high on the 4th, then tick=1 and done=1 for 1 cycle, busy=0, ticks=1.
- Periodic prescaled: preset=14, div=2, mode=1 -> a strobe every 3rd RUN cycle; tick pulses exactly 7 cycles apart; ticks=3 after 3 intervals.
- Hold: preset=13, div=1 periodic; assert hold for 5 cycles mid-RUN -> no strobes and pre frozen; the interval containing the hold is stretched by exactly 5 cycles.
- Stop coincident with terminal event: stop=1 in the carry cycle -> IDLE next cycle, tick=0, done=0, ticks unchanged.
- Start while busy and saturation: TICKS_W=2, periodic, preset=15, div=0, with start pulsed during RUN -> start ignored (ticks not cleared); ticks saturates at 3 after 4+ intervals.
